// File: rtl/countdown_timer.sv
// MM:SS countdown / stopwatch core with pause, configurable minute range and end-of-count blink.
// All state advances on MCLK; the 1 Hz step comes from a prescaler used as a clock enable.
module countdown_timer #(
  parameter int CLK_HZ    = 25175000,
  parameter int MAX_MIN   = 59,
  parameter int BLINK_DIV = 12587500
) (
  input  logic       MCLK,
  input  logic       RST,
  input  logic       START_STOP,
  input  logic       CLEAR,
  input  logic       ADD_SEC,
  input  logic       ADD_MIN,
  input  logic       COUNT_UP,
  output logic [3:0] MIN_1,
  output logic [3:0] MIN_0,
  output logic [2:0] SEC_1,
  output logic [3:0] SEC_0,
  output logic       RUNNING,
  output logic       DONE,
  output logic       DONE_PULSE,
  output logic       BLINK,
  output logic       TICK
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [3:0] MAX_T = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_U = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {ST_SET, ST_RUN, ST_DONE} state_t;

  state_t        state;
  logic [3:0]    min1, min0, sec0;
  logic [2:0]    sec1;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          mode_up, blink, tick_q, done_pulse_q;

  logic [3:0] sec_inc_0, sec_dec_0, min_inc_1, min_inc_0, min_dec_1, min_dec_0;
  logic [2:0] sec_inc_1, sec_dec_1;
  logic       sec_carry, sec_borrow;
  logic [3:0] step_min1, step_min0, step_sec0;
  logic [2:0] step_sec1;
  logic       step_end, time_zero, time_top, start_blocked, presc_wrap;

  // BCD neighbours of the current time, plus the one-second step in the latched direction.
  always_comb begin
    sec_inc_1 = sec1;
    sec_inc_0 = sec0 + 4'd1;
    sec_carry = 1'b0;
    if (sec0 == 4'd9) begin
      sec_inc_0 = 4'd0;
      if (sec1 == 3'd5) begin
        sec_inc_1 = 3'd0;
        sec_carry = 1'b1;
      end else begin
        sec_inc_1 = sec1 + 3'd1;
      end
    end

    sec_dec_1  = sec1;
    sec_dec_0  = sec0 - 4'd1;
    sec_borrow = 1'b0;
    if (sec0 == 4'd0) begin
      sec_dec_0 = 4'd9;
      if (sec1 == 3'd0) begin
        sec_dec_1  = 3'd5;
        sec_borrow = 1'b1;
      end else begin
        sec_dec_1 = sec1 - 3'd1;
      end
    end

    min_inc_1 = min1;
    min_inc_0 = min0 + 4'd1;
    if (min1 == MAX_T && min0 == MAX_U) begin
      min_inc_1 = 4'd0;
      min_inc_0 = 4'd0;
    end else if (min0 == 4'd9) begin
      min_inc_1 = min1 + 4'd1;
      min_inc_0 = 4'd0;
    end

    min_dec_1 = min1;
    min_dec_0 = min0 - 4'd1;
    if (min0 == 4'd0) begin
      min_dec_1 = min1 - 4'd1;
      min_dec_0 = 4'd9;
    end

    time_zero = (min1 == 4'd0) && (min0 == 4'd0) && (sec1 == 3'd0) && (sec0 == 4'd0);
    time_top  = (min1 == MAX_T) && (min0 == MAX_U) && (sec1 == 3'd5) && (sec0 == 4'd9);
    start_blocked = COUNT_UP ? time_top : time_zero;
    presc_wrap = (presc == PRESC_LAST);

    if (mode_up) begin
      step_sec1 = sec_inc_1;
      step_sec0 = sec_inc_0;
      step_min1 = sec_carry ? min_inc_1 : min1;
      step_min0 = sec_carry ? min_inc_0 : min0;
      step_end  = (step_min1 == MAX_T) && (step_min0 == MAX_U) &&
                  (step_sec1 == 3'd5) && (step_sec0 == 4'd9);
    end else begin
      step_sec1 = sec_dec_1;
      step_sec0 = sec_dec_0;
      step_min1 = sec_borrow ? min_dec_1 : min1;
      step_min0 = sec_borrow ? min_dec_0 : min0;
      step_end  = (step_min1 == 4'd0) && (step_min0 == 4'd0) &&
                  (step_sec1 == 3'd0) && (step_sec0 == 4'd0);
    end
  end

  // One action per cycle, chosen by the if/else order: CLEAR, START_STOP, ADD_MIN, ADD_SEC, tick.
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state        <= ST_SET;
      min1         <= 4'd0;
      min0         <= 4'd0;
      sec1         <= 3'd0;
      sec0         <= 4'd0;
      presc        <= '0;
      blink_cnt    <= '0;
      mode_up      <= 1'b0;
      blink        <= 1'b1;
      tick_q       <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      tick_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      case (state)
        ST_SET: begin
          presc <= '0;
          blink <= 1'b1;
          if (CLEAR) begin
            min1 <= 4'd0;
            min0 <= 4'd0;
            sec1 <= 3'd0;
            sec0 <= 4'd0;
          end else if (START_STOP && !start_blocked) begin
            mode_up <= COUNT_UP;
            state   <= ST_RUN;
          end else if (ADD_MIN) begin
            min1 <= min_inc_1;
            min0 <= min_inc_0;
          end else if (ADD_SEC) begin
            sec1 <= sec_inc_1;
            sec0 <= sec_inc_0;
          end
        end
        ST_RUN: begin
          if (START_STOP) begin
            presc <= '0;
            state <= ST_SET;
          end else if (presc_wrap) begin
            presc  <= '0;
            tick_q <= 1'b1;
            min1   <= step_min1;
            min0   <= step_min0;
            sec1   <= step_sec1;
            sec0   <= step_sec0;
            if (step_end) begin
              state        <= ST_DONE;
              done_pulse_q <= 1'b1;
              blink        <= 1'b1;
              blink_cnt    <= '0;
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end
        ST_DONE: begin
          if (CLEAR) begin
            min1  <= 4'd0;
            min0  <= 4'd0;
            sec1  <= 3'd0;
            sec0  <= 4'd0;
            blink <= 1'b1;
            state <= ST_SET;
          end else if (START_STOP) begin
            blink <= 1'b1;
            state <= ST_SET;
          end else if (blink_cnt == BLINK_LAST) begin
            blink     <= ~blink;
            blink_cnt <= '0;
          end else begin
            blink_cnt <= blink_cnt + BW'(1);
          end
        end
        default: state <= ST_SET;
      endcase
    end
  end

  assign MIN_1      = min1;
  assign MIN_0      = min0;
  assign SEC_1      = sec1;
  assign SEC_0      = sec0;
  assign RUNNING    = (state == ST_RUN);
  assign DONE       = (state == ST_DONE);
  assign DONE_PULSE = done_pulse_q;
  assign BLINK      = blink;
  assign TICK       = tick_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: stimulus queues expected output snapshots per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_countdown_timer;
  localparam int CLK_HZ    = 4;
  localparam int MAX_MIN   = 12;
  localparam int BLINK_DIV = 2;

  // Flag order: running, done, done_pulse, blink, tick
  localparam logic [4:0] SET_F  = 5'b00010;
  localparam logic [4:0] RUN_F  = 5'b10010;
  localparam logic [4:0] RUN_TK = 5'b10011;

  logic       clk = 1'b0;
  logic       rst, start_stop, clear, add_sec, add_min, count_up;
  logic [3:0] min_1, min_0, sec_0;
  logic [2:0] sec_1;
  logic       running, done, done_pulse, blink, tick;

  typedef struct {
    int          cyc;
    string       name;
    logic [19:0] vec;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;

  int         cd_ss [13] = '{2, 2, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  logic [4:0] cd_fl [13] = '{5'b10010, 5'b10010, 5'b10010, 5'b10011, 5'b10010, 5'b10010,
                             5'b10010, 5'b01111, 5'b01010, 5'b01000, 5'b01000, 5'b01010,
                             5'b01010};

  countdown_timer #(
    .CLK_HZ(CLK_HZ),
    .MAX_MIN(MAX_MIN),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .MCLK(clk),
    .RST(rst),
    .START_STOP(start_stop),
    .CLEAR(clear),
    .ADD_SEC(add_sec),
    .ADD_MIN(add_min),
    .COUNT_UP(count_up),
    .MIN_1(min_1),
    .MIN_0(min_0),
    .SEC_1(sec_1),
    .SEC_0(sec_0),
    .RUNNING(running),
    .DONE(done),
    .DONE_PULSE(done_pulse),
    .BLINK(blink),
    .TICK(tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string show(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d run=%0b done=%0b dp=%0b blink=%0b tick=%0b",
                     v[19:16], v[15:12], v[11:9], v[8:5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    logic [19:0] act;
    act = {min_1, min_0, sec_1, sec_0, running, done, done_pulse, blink, tick};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc)
        $display("[TB] FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      else if (act === e.vec)
        passes++;
      else
        $display("[TB] FAIL %s: got %s, required %s", e.name, show(act), show(e.vec));
    end
  end

  task automatic check_output(input string name, input int mm, input int ss, input logic [4:0] fl);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.vec  = {4'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10), fl};
    sb.push_back(e);
  endtask

  task automatic apply_stimulus(input logic ss, input logic cl, input logic am, input logic as);
    start_stop = ss;
    clear      = cl;
    add_min    = am;
    add_sec    = as;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    add_min    = 1'b0;
    add_sec    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; add_sec = 1'b0; add_min = 1'b0; count_up = 1'b0;
    apply_stimulus(0, 0, 0, 0);
    check_output("reset", 0, 0, SET_F);
    rst = 1'b0;

    apply_stimulus(1, 0, 0, 0);
    check_output("start_guard_zero", 0, 0, SET_F);

    // Countdown 00:02 -> done, then blink pattern and CLEAR acknowledge
    apply_stimulus(0, 0, 0, 1);
    check_output("add_sec_1", 0, 1, SET_F);
    apply_stimulus(0, 0, 0, 1);
    check_output("add_sec_2", 0, 2, SET_F);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_down", 0, 2, RUN_F);
    for (int k = 0; k < 13; k++) begin
      idle(1);
      check_output($sformatf("countdown_k%0d", k + 1), 0, cd_ss[k], cd_fl[k]);
    end
    apply_stimulus(0, 1, 0, 0);
    check_output("done_clear", 0, 0, SET_F);

    // Borrow 01:00 -> 00:59, pause on a tick edge, ignored edits while running
    apply_stimulus(0, 0, 1, 0);
    check_output("add_min_1", 1, 0, SET_F);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_borrow", 1, 0, RUN_F);
    idle(3);
    check_output("before_tick", 1, 0, RUN_F);
    idle(1);
    check_output("borrow_tick", 0, 59, RUN_TK);
    apply_stimulus(1, 0, 0, 0);
    check_output("pause", 0, 59, SET_F);
    apply_stimulus(1, 0, 0, 0);
    check_output("resume", 0, 59, RUN_F);
    idle(3);
    apply_stimulus(1, 0, 0, 0);
    check_output("pause_on_tick", 0, 59, SET_F);
    idle(1);
    check_output("after_pause", 0, 59, SET_F);
    apply_stimulus(1, 0, 0, 0);
    check_output("resume2", 0, 59, RUN_F);
    apply_stimulus(0, 0, 0, 1);
    check_output("run_add_sec", 0, 59, RUN_F);
    apply_stimulus(0, 1, 0, 0);
    check_output("run_clear", 0, 59, RUN_F);
    apply_stimulus(0, 0, 1, 0);
    check_output("run_add_min", 0, 59, RUN_F);
    idle(1);
    check_output("run_tick2", 0, 58, RUN_TK);
    apply_stimulus(1, 0, 0, 0);
    check_output("pause2", 0, 58, SET_F);
    apply_stimulus(0, 1, 0, 0);
    check_output("set_clear", 0, 0, SET_F);

    // Minute wrap at MAX_MIN, seconds wrap without carry
    for (int i = 1; i <= MAX_MIN + 1; i++) begin
      apply_stimulus(0, 0, 1, 0);
      check_output($sformatf("min_wrap_%0d", i), i % (MAX_MIN + 1), 0, SET_F);
    end
    apply_stimulus(0, 0, 1, 0);
    check_output("min_to_1", 1, 0, SET_F);
    for (int i = 1; i <= 60; i++) begin
      apply_stimulus(0, 0, 0, 1);
      check_output($sformatf("sec_wrap_%0d", i), 1, i % 60, SET_F);
    end

    // Count-up to the MAX_MIN:59 ceiling
    repeat (MAX_MIN - 1) apply_stimulus(0, 0, 1, 0);
    repeat (57) apply_stimulus(0, 0, 0, 1);
    check_output("preset_up", MAX_MIN, 57, SET_F);
    count_up = 1'b1;
    apply_stimulus(1, 0, 0, 0);
    check_output("start_up", MAX_MIN, 57, RUN_F);
    count_up = 1'b0;
    idle(4);
    check_output("up_tick1", MAX_MIN, 58, RUN_TK);
    idle(4);
    check_output("up_done", MAX_MIN, 59, 5'b01111);
    idle(1);
    check_output("up_hold1", MAX_MIN, 59, 5'b01010);
    idle(1);
    check_output("up_hold2", MAX_MIN, 59, 5'b01000);
    apply_stimulus(1, 0, 0, 0);
    check_output("done_ack", MAX_MIN, 59, SET_F);
    count_up = 1'b1;
    apply_stimulus(1, 0, 0, 0);
    check_output("ceiling_guard", MAX_MIN, 59, SET_F);
    count_up = 1'b0;

    // Reset in the middle of a run at 03:27, on the tick edge
    apply_stimulus(0, 1, 0, 0);
    check_output("clear_again", 0, 0, SET_F);
    repeat (3) apply_stimulus(0, 0, 1, 0);
    repeat (27) apply_stimulus(0, 0, 0, 1);
    check_output("preset_327", 3, 27, SET_F);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_327", 3, 27, RUN_F);
    idle(3);
    check_output("run_327", 3, 27, RUN_F);
    rst = 1'b1;
    apply_stimulus(0, 0, 0, 0);
    check_output("reset_mid_run", 0, 0, SET_F);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check_output($sformatf("post_reset_%0d", i), 0, 0, SET_F);
    end

    idle(2);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("[TB] FAIL %s: expectation never compared", e.name);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
